// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks the shared datapath through fetch/decode/exec/mem/wb,
// arbitrates the single memory port and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_data,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StTrap   = 3'd6;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Last wait cycle index: a miss here means TIMEOUT cycles have elapsed without mem_ready.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic is_legal, is_store, is_load, is_jal;

  always_comb begin
    unique case (opcode)
      OpR, OpLoad, OpImm, OpStore, OpBranch, OpJal, OpLui, OpAuipc: is_legal = 1'b1;
      default:                                                      is_legal = 1'b0;
    endcase
  end

  assign is_store = (opcode == OpStore);
  assign is_load  = (opcode == OpLoad);
  assign is_jal   = (opcode == OpJal);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    instret_d   = instret_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 1'b0;
    aluop       = 2'b00;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          wait_d  = '0;
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          wait_d    = '0;
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      StDecode: begin
        if (is_legal) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end
      end

      StExec: begin
        case (opcode)
          OpR: begin
            aluop   = 2'b10;
            state_d = StWb;
          end
          OpImm: begin
            alu_src_b = 1'b1;
            aluop     = 2'b11;
            state_d   = StWb;
          end
          OpLoad, OpStore: begin
            alu_src_b = 1'b1;
            state_d   = StMem;
          end
          OpLui: begin
            alu_src_a = 2'd2;
            alu_src_b = 1'b1;
            state_d   = StWb;
          end
          OpAuipc, OpJal: begin
            alu_src_a = 2'd1;
            alu_src_b = 1'b1;
            state_d   = StWb;
          end
          OpBranch: begin
            aluop     = 2'b01;
            pc_we     = 1'b1;
            pc_sel    = branch_taken;
            instret_d = instret_q + CNT_W'(1);
            state_d   = StFetch;
          end
          // IR changed under us; treat as illegal rather than guess a class.
          default: begin
            illegal_d = 1'b1;
            state_d   = StTrap;
          end
        endcase
      end

      StMem: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = is_store;
        if (mem_ready) begin
          wait_d = '0;
          if (is_store) begin
            pc_we     = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          wait_d    = '0;
          bus_err_d = 1'b1;
          state_d   = StTrap;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      StWb: begin
        reg_we    = 1'b1;
        wb_sel    = is_load ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
        pc_we     = 1'b1;
        pc_sel    = is_jal;
        instret_d = instret_q + CNT_W'(1);
        state_d   = StFetch;
      end

      default: state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instret = instret_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core.
- Steps the shared datapath through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives the per-state strobes: PC, IR, register-file and memory enables, ALU operand selects and ALU op.
- Shares the single memory port between instruction fetch and load/store, with a ready handshake and a wait timeout.
- Sits between the instruction register (opcode source) and the datapath/ALU-control block.

Parameters:
TIMEOUT, 255, maximum mem_ready wait cycles before bus error (1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  7  IR[6:0]; stable from DECODE until next ir_we
branch_taken  input  1  ALU compare result, valid in EXEC
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request
mem_we  output  1  store request (only with mem_req)
mem_is_data  output  1  address mux: 0 = PC, 1 = ALU result
ir_we  output  1  latch instruction
pc_we  output  1  update PC
pc_sel  output  1  0 = PC+4, 1 = ALU target
reg_we  output  1  register-file write
wb_sel  output  2  0 ALU, 1 mem data, 2 PC+4
alu_src_a  output  2  0 rs1, 1 PC, 2 zero
alu_src_b  output  1  0 rs2, 1 imm
aluop  output  2  00 add, 01 branch compare, 10 R-funct, 11 I-funct
illegal  output  1  sticky illegal-opcode flag
bus_err  output  1  sticky memory-timeout flag
instret  output  CNT_W  retired instruction count

Behaviour:
- Reset (async, reset_n low): state=IDLE, instret=0, illegal=0, bus_err=0, wait counter=0. All strobes are 0 while in IDLE.
- All strobe outputs are combinational from state and opcode (Moore plus opcode class). Any output not listed for a state is 0.
- IDLE: one cycle, then FETCH.
- FETCH: mem_req=1, mem_is_data=0. While mem_ready=0, stay and increment the wait counter. On mem_ready=1: ir_we=1, clear the counter, go to DECODE.
- DECODE: classify opcode. Legal classes:
  - R 0110011
  - LOAD 0000011
  - IMM 0010011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - LUI 0110111
  - AUIPC 0010111
  Any other opcode → TRAP and set illegal. Legal → EXEC.
- EXEC per class:
  - R: src_a=0, src_b=0, aluop=10 → WB.
  - IMM: src_a=0, src_b=1, aluop=11 → WB.
  - LOAD/STORE: src_a=0, src_b=1, aluop=00 → MEM.
  - LUI: src_a=2, src_b=1, aluop=00 → WB.
  - AUIPC and JAL: src_a=1, src_b=1, aluop=00 → WB.
  - BRANCH: aluop=01, src_a=0, src_b=0, pc_we=1, pc_sel=branch_taken, instret+1 → FETCH.
- MEM: mem_req=1, mem_is_data=1, mem_we=1 for STORE. Address/ALU result is held by the datapath ALU-out register. Wait as in FETCH. On mem_ready:
  - LOAD → WB.
  - STORE → pc_we=1, pc_sel=0, instret+1 → FETCH.
- WB: reg_we=1.
  - wb_sel: 1 for LOAD, 2 for JAL, else 0.
  - pc_we=1; pc_sel=1 for JAL, else 0.
  - instret+1 → FETCH.
  - AUIPC writes rd (reg_we=1).
- Timeout: the wait counter counts cycles in FETCH/MEM with mem_ready=0. When it reaches TIMEOUT with mem_ready still 0, go to TRAP and set bus_err. mem_ready in the same cycle the counter reaches TIMEOUT wins, and the transaction completes normally.
- TRAP: all strobes 0. Stays until reset. illegal and bus_err are sticky.
- Latencies with zero wait states:
  - ALU/LUI/AUIPC/JAL: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- instret wraps modulo 2^CNT_W. It increments exactly once per retired instruction and never in TRAP.
- Reset asserted mid-access drops mem_req immediately (async) and returns to IDLE. No PC or register write may occur in the reset cycle.
- mem_we is never 1 without mem_req. Only one of ir_we, reg_we, or a store is active in any cycle.

Test Plan:
- Reset release, mem_ready tied 1, opcode 0110011 → IDLE, then FETCH (mem_req=1, ir_we=1), DECODE, EXEC (aluop=10), WB (reg_we=1, wb_sel=0, pc_we=1); instret=1 after 5 cycles.
- LOAD 0000011, mem_ready low for 3 cycles in MEM → mem_req held 3+1 cycles with mem_is_data=1, then WB with wb_sel=1; total 8 cycles from FETCH; STORE 0100011 → mem_we=1, no reg_we, pc_we in MEM exit cycle.
- BRANCH with branch_taken=1 → EXEC pc_we=1, pc_sel=1, back to FETCH after 3 cycles; with 0 → pc_sel=0.
- JAL → EXEC src_a=1, src_b=1; WB reg_we=1, wb_sel=2, pc_sel=1. LUI → src_a=2. AUIPC → reg_we=1.
- Opcode 1111111 → TRAP, illegal=1, all strobes 0 for 20 cycles, instret unchanged; reset_n pulse clears illegal.
- TIMEOUT=4, mem_ready=0 in FETCH → bus_err=1 after 4 wait cycles. Separately, mem_ready=1 on the 4th cycle → normal completion, no bus_err. Reset asserted during a MEM wait → mem_req falls asynchronously, state returns to IDLE.
